// File: rtl/branch_predict_unit.sv
// Branch resolution plus a direct-mapped BHT/BTB for fetch-stage prediction.
// Fetch reads combinationally; execute resolves and trains the tables on the clock edge.
module branch_predict_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  f_pc,
  output logic                   f_pred_taken,
  output logic [DATA_WIDTH-1:0]  f_pred_target,
  input  logic                   ex_valid,
  input  logic [DATA_WIDTH-1:0]  ex_pc,
  input  logic [DATA_WIDTH-1:0]  ex_target,
  input  logic                   ex_pred_taken,
  input  logic [DATA_WIDTH-1:0]  ex_pred_target,
  input  logic [DATA_WIDTH-1:0]  data_1,
  input  logic [DATA_WIDTH-1:0]  data_2,
  input  logic [2:0]             branch_sel,
  input  logic                   perf_clr,
  output logic                   ex_taken,
  output logic                   ex_mispredict,
  output logic [DATA_WIDTH-1:0]  ex_redirect_pc,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [2:0] SEL_BEQ  = 3'b000;
  localparam logic [2:0] SEL_BNE  = 3'b001;
  localparam logic [2:0] SEL_NONE = 3'b010;
  localparam logic [2:0] SEL_JUMP = 3'b011;
  localparam logic [2:0] SEL_BLT  = 3'b100;
  localparam logic [2:0] SEL_BGE  = 3'b101;
  localparam logic [2:0] SEL_BGEU = 3'b110;
  localparam logic [2:0] SEL_BLTU = 3'b111;

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] cnt_next(input logic [COUNT_WIDTH-1:0] c,
                                                      input logic clr, input logic inc);
    if (clr)      return '0;
    else if (inc) return c + COUNT_WIDTH'(1);
    else          return c;
  endfunction

  logic [1:0]            ctr [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] v;
  logic [DATA_WIDTH-1:0] tgt [BHT_ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_f_pc;

  assign f_idx       = f_pc[IDX_W+1:2];
  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign unused_f_pc = ^{f_pc[DATA_WIDTH-1:IDX_W+2], f_pc[1:0]};

  // Fetch: read old table contents; writes become visible after the edge
  assign f_pred_taken  = v[f_idx] & ctr[f_idx][1];
  assign f_pred_target = tgt[f_idx];

  logic signed [DATA_WIDTH-1:0] op_a;
  logic signed [DATA_WIDTH-1:0] op_b;
  logic                         eq;
  logic                         lt_s;
  logic                         lt_u;
  logic                         cond_taken;

  assign op_a = data_1;
  assign op_b = data_2;
  assign eq   = (data_1 == data_2);
  assign lt_s = (op_a < op_b);
  assign lt_u = (data_1 < data_2);

  always_comb begin
    cond_taken = 1'b0;
    case (branch_sel)
      SEL_BEQ:  cond_taken = eq;
      SEL_BNE:  cond_taken = ~eq;
      SEL_NONE: cond_taken = 1'b0;
      SEL_JUMP: cond_taken = 1'b1;
      SEL_BLT:  cond_taken = lt_s;
      SEL_BGE:  cond_taken = ~lt_s;
      SEL_BGEU: cond_taken = ~lt_u;
      SEL_BLTU: cond_taken = lt_u;
      default:  cond_taken = 1'b0;
    endcase
  end

  // Resolve: a predicted-taken non-branch (alias) also counts as a mispredict
  assign ex_taken       = ex_valid & cond_taken;
  assign ex_mispredict  = ex_valid &
                          ((ex_taken != ex_pred_taken) |
                           (ex_taken & ex_pred_taken & (ex_pred_target != ex_target)));
  assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);

  logic upd;
  assign upd = ex_valid & (branch_sel != SEL_NONE);

  // Table update on the resolving edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr[i] <= 2'b01;
        tgt[i] <= '0;
      end
      v <= '0;
    end else if (upd) begin
      v[ex_idx] <= 1'b1;
      if (branch_sel == SEL_JUMP) begin
        ctr[ex_idx] <= 2'b11;
        tgt[ex_idx] <= ex_target;
      end else begin
        ctr[ex_idx] <= ctr_sat(ctr[ex_idx], ex_taken);
        if (ex_taken) tgt[ex_idx] <= ex_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      branch_count     <= cnt_next(branch_count, perf_clr, upd);
      mispredict_count <= cnt_next(mispredict_count, perf_clr, ex_mispredict);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven and sequence checks for branch_predict_unit with an expected-result queue.
module tb_branch_predict_unit;

  localparam int DW = 32;
  localparam int CW = 4;

  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, NONE = 3'b010, JMP = 3'b011;
  localparam logic [2:0] BLT = 3'b100, BGE = 3'b101, BGEU = 3'b110, BLTU = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] f_pc = '0;
  logic          f_pred_taken;
  logic [DW-1:0] f_pred_target;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic          ex_pred_taken = 1'b0;
  logic [DW-1:0] data_1 = '0, data_2 = '0;
  logic [2:0]    branch_sel = NONE;
  logic          perf_clr = 1'b0;
  logic          ex_taken, ex_mispredict;
  logic [DW-1:0] ex_redirect_pc;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_predict_unit #(.DATA_WIDTH(DW), .BHT_ENTRIES(64), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .f_pred_target(f_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .data_1(data_1), .data_2(data_2),
    .branch_sel(branch_sel), .perf_clr(perf_clr), .ex_taken(ex_taken),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [2:0]    sel;
    logic [DW-1:0] pc, tgt;
    logic          pt;
    logic [DW-1:0] ptgt, d1, d2;
    logic          et, em;
    logic [DW-1:0] er;
  } vec_t;

  typedef struct {
    logic          taken, misp;
    logic [DW-1:0] redir;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] bc_m = '0, mc_m = '0;
  vec_t          vt[16];

  function automatic vec_t mk(logic val, logic [2:0] s, logic [DW-1:0] pc, logic [DW-1:0] tg,
                              logic pt, logic [DW-1:0] ptg, logic [DW-1:0] d1,
                              logic [DW-1:0] d2, logic et, logic em, logic [DW-1:0] er);
    vec_t r;
    r.valid = val; r.sel = s; r.pc = pc; r.tgt = tg; r.pt = pt; r.ptgt = ptg;
    r.d1 = d1; r.d2 = d2; r.et = et; r.em = em; r.er = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic clr, input string nm);
    exp_t e;
    @(negedge clk);
    ex_valid = v.valid; branch_sel = v.sel; ex_pc = v.pc; ex_target = v.tgt;
    ex_pred_taken = v.pt; ex_pred_target = v.ptgt; data_1 = v.d1; data_2 = v.d2;
    perf_clr = clr;
    e.taken = v.et; e.misp = v.em; e.redir = v.er;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk({nm, "_taken"}, DW'(ex_taken), DW'(e.taken));
    chk({nm, "_misp"}, DW'(ex_mispredict), DW'(e.misp));
    if (e.misp) chk({nm, "_redir"}, ex_redirect_pc, e.redir);
    if (clr) begin
      bc_m = '0; mc_m = '0;
    end else begin
      if (v.valid && v.sel != NONE) bc_m = bc_m + 1'b1;
      if (e.misp) mc_m = mc_m + 1'b1;
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0; perf_clr = 1'b0;
    chk({nm, "_bcnt"}, DW'(branch_count), DW'(bc_m));
    chk({nm, "_mcnt"}, DW'(mispredict_count), DW'(mc_m));
  endtask

  task automatic fetch(input logic [DW-1:0] pc, input logic et, input logic [DW-1:0] etg,
                       input string nm);
    f_pc = pc;
    #1;
    chk({nm, "_ptaken"}, DW'(f_pred_taken), DW'(et));
    chk({nm, "_ptgt"}, f_pred_target, etg);
  endtask

  initial begin
    vt[0]  = mk(1, BLT,  32'h20, 32'h500, 0, 32'h0,   32'hFFFFFFFF, 32'h1, 1, 1, 32'h500);
    vt[1]  = mk(1, BLTU, 32'h20, 32'h500, 0, 32'h0,   32'hFFFFFFFF, 32'h1, 0, 0, 32'h0);
    vt[2]  = mk(1, BGE,  32'h20, 32'h500, 1, 32'h500, 32'hFFFFFFFF, 32'h1, 0, 1, 32'h24);
    vt[3]  = mk(1, BGEU, 32'h20, 32'h500, 1, 32'h500, 32'hFFFFFFFF, 32'h1, 1, 0, 32'h0);
    vt[4]  = mk(1, BEQ,  32'h20, 32'h700, 1, 32'h600, 32'h5, 32'h5, 1, 1, 32'h700);
    vt[5]  = mk(1, BNE,  32'h20, 32'h700, 0, 32'h0,   32'h5, 32'h5, 0, 0, 32'h0);
    vt[6]  = mk(1, BNE,  32'h20, 32'h700, 0, 32'h0,   32'h5, 32'h6, 1, 1, 32'h700);
    vt[7]  = mk(1, NONE, 32'h20, 32'h700, 0, 32'h0,   32'h5, 32'h5, 0, 0, 32'h0);
    vt[8]  = mk(1, JMP,  32'h20, 32'h900, 1, 32'h900, 32'h0, 32'h0, 1, 0, 32'h0);
    vt[9]  = mk(0, BLT,  32'h20, 32'h500, 1, 32'h500, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0);
    vt[10] = mk(1, BLT,  32'h20, 32'h500, 0, 32'h0,   32'h7, 32'h7, 0, 0, 32'h0);
    vt[11] = mk(1, BGE,  32'h20, 32'h500, 1, 32'h500, 32'h7, 32'h7, 1, 0, 32'h0);
    vt[12] = mk(1, BEQ,  32'hFFFFFFFC, 32'h500, 1, 32'h500, 32'h1, 32'h2, 0, 1, 32'h0);
    vt[13] = mk(1, BLT,  32'h20, 32'h500, 1, 32'h500, 32'h80000000, 32'h7FFFFFFF, 1, 0, 32'h0);
    vt[14] = mk(1, BLTU, 32'h20, 32'h500, 1, 32'h500, 32'h80000000, 32'h7FFFFFFF, 0, 1, 32'h24);
    vt[15] = mk(1, JMP,  32'h20, 32'h900, 0, 32'h0,   32'h0, 32'h0, 1, 1, 32'h900);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h20, 0, 32'h0, "rst0");
    chk("rst0_bcnt", DW'(branch_count), 32'h0);
    chk("rst0_mcnt", DW'(mispredict_count), 32'h0);

    for (int i = 0; i < 16; i++) apply(vt[i], 1'b0, $sformatf("vec%0d", i));
    fetch(32'h20, 1, 32'h900, "vec_trained");

    // Asynchronous reset landing in the middle of an update cycle
    @(negedge clk);
    ex_valid = 1'b1; branch_sel = BEQ; ex_pc = 32'h24; ex_target = 32'h444;
    data_1 = 32'h1; data_2 = 32'h1; ex_pred_taken = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 64; i++) fetch(32'(i * 4), 0, 32'h0, $sformatf("rst_idx%0d", i));
    chk("rst_bcnt", DW'(branch_count), 32'h0);
    chk("rst_mcnt", DW'(mispredict_count), 32'h0);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; rst = 1'b0;
    bc_m = '0; mc_m = '0;
    fetch(32'h24, 0, 32'h0, "rst_noupd");

    // Training at pc 0x100, target 0x80
    fetch(32'h100, 0, 32'h0, "trn_init");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 3, 1, 1, 32'h80), 1'b0, "trn_t1");
    fetch(32'h100, 1, 32'h80, "trn_t1");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 3, 1, 1, 32'h80), 1'b0, "trn_t2");
    fetch(32'h100, 1, 32'h80, "trn_t2");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 4, 0, 0, 32'h0), 1'b0, "trn_n1");
    fetch(32'h100, 1, 32'h80, "trn_n1");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 4, 0, 0, 32'h0), 1'b0, "trn_n2");
    fetch(32'h100, 0, 32'h80, "trn_n2");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 4, 0, 0, 32'h0), 1'b0, "trn_n3");
    fetch(32'h100, 0, 32'h80, "trn_n3");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 4, 0, 0, 32'h0), 1'b0, "trn_n4");
    fetch(32'h100, 0, 32'h80, "trn_n4");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 3, 1, 1, 32'h80), 1'b0, "trn_t3");
    fetch(32'h100, 0, 32'h80, "trn_t3");
    apply(mk(1, BEQ, 32'h100, 32'h80, 0, 0, 3, 3, 1, 1, 32'h80), 1'b0, "trn_t4");
    fetch(32'h100, 1, 32'h80, "trn_t4");

    // Jump whose carried prediction has the wrong target
    apply(mk(1, JMP, 32'h40, 32'h300, 1, 32'h200, 0, 0, 1, 1, 32'h300), 1'b0, "jmp");
    fetch(32'h40, 1, 32'h300, "jmp");

    // Non-branch predicted taken through aliasing
    apply(mk(1, NONE, 32'h10, 32'h999, 1, 32'h999, 0, 0, 0, 1, 32'h14), 1'b0, "alias");
    fetch(32'h10, 0, 32'h0, "alias");

    // Counter wrap and clear priority
    apply(mk(0, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "clr");
    for (int i = 0; i < 16; i++)
      apply(mk(1, JMP, 32'h8, 32'h8, 1, 32'h8, 0, 0, 1, 0, 0), 1'b0, $sformatf("wrap%0d", i));
    apply(mk(1, JMP, 32'h8, 32'h8, 0, 0, 0, 0, 1, 1, 32'h8), 1'b0, "misp_one");
    apply(mk(1, JMP, 32'h8, 32'h8, 0, 0, 0, 0, 1, 1, 32'h8), 1'b1, "clr_misp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
